z80_bus_arbiter: RTL

- Shares the Z80 external bus between the CPU and two external bus masters, ch0 and ch1 (DMA engines, test masters).
- Asks the CPU for the bus with nBUSRQ and waits for nBUSACK.
- Grants the bus to one master at a time using a req/gnt handshake.
- Limits how long the bus is held, then forces a CPU cooldown window so DRAM refresh and instruction flow continue.
- Sits beside the CPU on the pin-level (tb-side) bus interface.

---
 rtl/z80_bus_arbiter.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/z80_bus_arbiter.sv
// ============================================================================
// Module   : z80_bus_arbiter
// Purpose  : Shares the Z80 external bus between the CPU and two external
//            bus masters (ch0, ch1). Requests the bus from the CPU with
//            nBUSRQ, waits for nBUSACK, grants one master at a time, limits
//            tenure to MAX_HOLD cycles and then enforces a MIN_CPU cycle
//            cooldown during which the CPU keeps the bus.
// Ports    : CLK      - system clock, rising edge
//            nRESET   - asynchronous active-low reset
//            req0/1   - level bus requests from ch0/ch1
//            gnt0/1   - registered bus grants
//            yield    - owner has reached the hold limit and must drop req
//            drive_en - gnt0|gnt1, enables master drivers on A/D/control
//            err      - sticky protocol error (nBUSACK lost during a grant)
//            nBUSRQ   - bus request to the CPU, active-low
//            nBUSACK  - bus acknowledge from the CPU, active-low, CLK-synchronous
// Options  : `define Z80_ARB_RR_EN selects round-robin arbitration between
//            the two channels; without it ch0 has fixed priority over ch1.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module z80_bus_arbiter #(
  parameter int MAX_HOLD = 64,
  parameter int MIN_CPU  = 8,
  parameter int CW       = 8
) (
  input  logic CLK,
  input  logic nRESET,
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1,
  output logic yield,
  output logic drive_en,
  output logic err,
  output logic nBUSRQ,
  input  logic nBUSACK
);

  localparam logic [2:0] c_IDLE     = 3'd0;
  localparam logic [2:0] c_REQ      = 3'd1;
  localparam logic [2:0] c_GRANT    = 3'd2;
  localparam logic [2:0] c_SWITCH   = 3'd3;
  localparam logic [2:0] c_RELEASE  = 3'd4;
  localparam logic [2:0] c_COOLDOWN = 3'd5;

  localparam logic [CW-1:0] c_ZERO        = '0;
  localparam logic [CW-1:0] c_ONE         = CW'(1);
  localparam logic [CW-1:0] c_MAX_HOLD    = CW'(MAX_HOLD);
  localparam logic [CW-1:0] c_MIN_CPU_M1  = CW'(MIN_CPU - 1);

  logic [2:0]    state_q, state_d;
  logic          owner_q, owner_d;   // 0 = ch0, 1 = ch1
  logic [CW-1:0] hold_q, hold_d;
  logic [CW-1:0] cpu_q, cpu_d;
  logic          err_q, err_d;
  logic          gnt0_q, gnt0_d;
  logic          gnt1_q, gnt1_d;
  logic          yield_q, yield_d;
  logic          drive_en_q, drive_en_d;
  logic          nbusrq_q, nbusrq_d;

  logic          w_winner;
  logic          w_own_req;
  logic          w_oth_req;
  logic [CW-1:0] w_hold_inc;

  assign w_own_req  = owner_q ? req1 : req0;
  assign w_oth_req  = owner_q ? req0 : req1;
  assign w_hold_inc = (hold_q >= c_MAX_HOLD) ? hold_q : hold_q + c_ONE;

`ifdef Z80_ARB_RR_EN
  // Most recently granted channel loses a tie.
  logic last_q, last_d;

  always_comb begin
    if (req0 && req1) begin
      w_winner = ~last_q;
    end else begin
      w_winner = ~req0;
    end
  end

  always_comb begin
    last_d = last_q;
    if ((state_d == c_GRANT) && (state_q != c_GRANT)) begin
      last_d = owner_d;
    end
  end

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end
`else
  assign w_winner = ~req0;
`endif

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    hold_d  = hold_q;
    cpu_d   = cpu_q;
    err_d   = err_q;
    case (state_q)
      c_IDLE: begin
        if (req0 || req1) begin
          state_d = c_REQ;
        end
      end
      c_REQ: begin
        if (!req0 && !req1) begin
          state_d = c_RELEASE;
        end else if (!nBUSACK) begin
          state_d = c_GRANT;
          owner_d = w_winner;
          // Tenure is counted from the acknowledge sample, so the first
          // granted cycle is tenure cycle 1 and yield appears in granted
          // cycle MAX_HOLD.
          hold_d  = c_ONE;
        end
      end
      c_GRANT: begin
        hold_d = w_hold_inc;
        if (nBUSACK) begin
          err_d   = 1'b1;
          state_d = c_RELEASE;
        end else if (!w_own_req) begin
          // A handoff is only allowed while the tenure limit is not reached.
          if (w_oth_req && (hold_q < c_MAX_HOLD)) begin
            state_d = c_SWITCH;
          end else begin
            state_d = c_RELEASE;
          end
        end
      end
      c_SWITCH: begin
        hold_d = w_hold_inc;
        if (w_oth_req) begin
          state_d = c_GRANT;
          owner_d = ~owner_q;
        end else begin
          state_d = c_RELEASE;
        end
      end
      c_RELEASE: begin
        if (nBUSACK) begin
          state_d = c_COOLDOWN;
          cpu_d   = c_ZERO;
        end
      end
      c_COOLDOWN: begin
        // cpu_q runs 0..MIN_CPU-1, giving exactly MIN_CPU cooldown cycles.
        if (cpu_q >= c_MIN_CPU_M1) begin
          state_d = c_IDLE;
        end else begin
          cpu_d = cpu_q + c_ONE;
        end
      end
      default: begin
        state_d = c_IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so they are registered yet
  // line up with the state they describe.
  always_comb begin
    gnt0_d     = (state_d == c_GRANT) && !owner_d;
    gnt1_d     = (state_d == c_GRANT) &&  owner_d;
    drive_en_d = (state_d == c_GRANT);
    yield_d    = (state_d == c_GRANT) && (hold_d >= c_MAX_HOLD);
    nbusrq_d   = !((state_d == c_REQ) || (state_d == c_GRANT) ||
                   (state_d == c_SWITCH));
  end

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      state_q    <= c_IDLE;
      owner_q    <= 1'b0;
      hold_q     <= c_ZERO;
      cpu_q      <= c_ZERO;
      err_q      <= 1'b0;
      gnt0_q     <= 1'b0;
      gnt1_q     <= 1'b0;
      yield_q    <= 1'b0;
      drive_en_q <= 1'b0;
      nbusrq_q   <= 1'b1;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      hold_q     <= hold_d;
      cpu_q      <= cpu_d;
      err_q      <= err_d;
      gnt0_q     <= gnt0_d;
      gnt1_q     <= gnt1_d;
      yield_q    <= yield_d;
      drive_en_q <= drive_en_d;
      nbusrq_q   <= nbusrq_d;
    end
  end

  assign gnt0     = gnt0_q;
  assign gnt1     = gnt1_q;
  assign yield    = yield_q;
  assign drive_en = drive_en_q;
  assign err      = err_q;
  assign nBUSRQ   = nbusrq_q;

endmodule

`default_nettype wire
